// File: rtl/gtx_tx_phase_sync.sv
// GTX TX buffer-bypass phase-alignment sequencer (TXENPMAPHASEALIGN then TXPMASETPHASE).
// Optional macro TX_PHASE_RESYNC_EN: loss of TXRESETDONE in Sync_Done reruns the sequence.
module gtx_tx_phase_sync #(
    parameter int ALIGN_WAIT = 32,
    parameter int PHASE_WAIT = 8192,
    parameter int CNT_W      = 14
) (
    input  logic CLK,
    input  logic RST,
    input  logic GTX_RST,
    input  logic TX_RESETDONE,
    output logic TXENPMAPHASEALIGN,
    output logic TXPMASETPHASE,
    output logic SYNC_DONE,
    output logic SYNC_BUSY
);

    typedef enum logic [2:0] {
        ST_RST_HOLD,
        ST_W4_RST_DONE,
        ST_ALIGN_WAIT,
        ST_PHASE_SET,
        ST_SYNC_DONE
    } state_t;

    localparam logic [CNT_W-1:0] ALIGN_LAST = CNT_W'(ALIGN_WAIT - 1);
    localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(PHASE_WAIT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_sync1;
    logic             r_rd_s;
    logic             r_txen;
    logic             r_txpma;
    logic             r_done;
    logic             r_busy;
    logic             w_txen;
    logic             w_txpma;
    logic             w_done;
    logic             w_busy;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync1 <= 1'b0;
            r_rd_s  <= 1'b0;
            r_state <= ST_RST_HOLD;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= TX_RESETDONE;
            r_rd_s  <= r_sync1;
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // GTX_RST overrides everything; losing rd_s mid-sequence restarts from W4RstDone.
    always_comb begin
        w_next = r_state;
        if (GTX_RST) begin
            w_next = ST_RST_HOLD;
        end else begin
            case (r_state)
                ST_RST_HOLD:    w_next = ST_W4_RST_DONE;
                ST_W4_RST_DONE: if (r_rd_s) w_next = ST_ALIGN_WAIT;
                ST_ALIGN_WAIT: begin
                    if (!r_rd_s)                 w_next = ST_W4_RST_DONE;
                    else if (r_cnt == ALIGN_LAST) w_next = ST_PHASE_SET;
                end
                ST_PHASE_SET: begin
                    if (!r_rd_s)                 w_next = ST_W4_RST_DONE;
                    else if (r_cnt == PHASE_LAST) w_next = ST_SYNC_DONE;
                end
                ST_SYNC_DONE: begin
`ifdef TX_PHASE_RESYNC_EN
                    if (!r_rd_s) w_next = ST_W4_RST_DONE;
`else
                    w_next = ST_SYNC_DONE;
`endif
                end
                default:        w_next = ST_RST_HOLD;
            endcase
        end
    end

    // Counter restarts on every state change and saturates at the terminal value.
    always_comb begin
        w_cnt_next = r_cnt;
        if (w_next != r_state) begin
            w_cnt_next = '0;
        end else if ((r_state == ST_ALIGN_WAIT && r_cnt != ALIGN_LAST) ||
                     (r_state == ST_PHASE_SET  && r_cnt != PHASE_LAST)) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
    end

    // NOTE: every output gets a default first so this decode cannot infer latches.
    always_comb begin
        w_txen  = 1'b0;
        w_txpma = 1'b0;
        w_done  = 1'b0;
        w_busy  = 1'b0;
        case (w_next)
            ST_W4_RST_DONE: w_busy = 1'b1;
            ST_ALIGN_WAIT: begin
                w_txen = 1'b1;
                w_busy = 1'b1;
            end
            ST_PHASE_SET: begin
                w_txen  = 1'b1;
                w_txpma = 1'b1;
                w_busy  = 1'b1;
            end
            ST_SYNC_DONE: begin
                w_txen = 1'b1;
                w_done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_txen  <= 1'b0;
            r_txpma <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_txen  <= w_txen;
            r_txpma <= w_txpma;
            r_done  <= w_done;
            r_busy  <= w_busy;
        end
    end

    assign TXENPMAPHASEALIGN = r_txen;
    assign TXPMASETPHASE     = r_txpma;
    assign SYNC_DONE         = r_done;
    assign SYNC_BUSY         = r_busy;

`ifndef SYNTHESIS
    string statename;
    always_comb begin
        case (r_state)
            ST_RST_HOLD:    statename = "Rst_Hold";
            ST_W4_RST_DONE: statename = "W4RstDone";
            ST_ALIGN_WAIT:  statename = "Align_Wait";
            ST_PHASE_SET:   statename = "Phase_Set";
            ST_SYNC_DONE:   statename = "Sync_Done";
            default:        statename = "Unknown";
        endcase
    end
`endif

endmodule

// File: tb/tb_gtx_tx_phase_sync.sv
// Directed bench for gtx_tx_phase_sync with ALIGN_WAIT=4, PHASE_WAIT=16.
// Output vector order: {TXENPMAPHASEALIGN, TXPMASETPHASE, SYNC_DONE, SYNC_BUSY}.
module tb_gtx_tx_phase_sync;

    logic       CLK = 1'b0;
    logic       RST;
    logic       GTX_RST;
    logic       TX_RESETDONE;
    logic       TXENPMAPHASEALIGN;
    logic       TXPMASETPHASE;
    logic       SYNC_DONE;
    logic       SYNC_BUSY;
    logic [3:0] outs;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [3:0] O_IDLE  = 4'b0000;
    localparam logic [3:0] O_W4    = 4'b0001;
    localparam logic [3:0] O_ALIGN = 4'b1001;
    localparam logic [3:0] O_PHASE = 4'b1101;
    localparam logic [3:0] O_DONE  = 4'b1010;

    gtx_tx_phase_sync #(
        .ALIGN_WAIT(4),
        .PHASE_WAIT(16),
        .CNT_W     (14)
    ) dut (
        .CLK              (CLK),
        .RST              (RST),
        .GTX_RST          (GTX_RST),
        .TX_RESETDONE     (TX_RESETDONE),
        .TXENPMAPHASEALIGN(TXENPMAPHASEALIGN),
        .TXPMASETPHASE    (TXPMASETPHASE),
        .SYNC_DONE        (SYNC_DONE),
        .SYNC_BUSY        (SYNC_BUSY)
    );

    assign outs = {TXENPMAPHASEALIGN, TXPMASETPHASE, SYNC_DONE, SYNC_BUSY};

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish (got running, expected done)");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    endtask

    // Inputs are driven and outputs sampled 1 time unit after each rising edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Expects the next edge to enter Align_Wait; checks 4 align cycles, 16 phase cycles, done.
    task automatic seq_from_align(input string tag);
        tick(); check({tag, "_align_rise"}, outs, O_ALIGN);
        for (int i = 0; i < 3; i++) begin
            tick(); check({tag, "_align_hold"}, outs, O_ALIGN);
        end
        tick(); check({tag, "_phase_rise"}, outs, O_PHASE);
        for (int i = 0; i < 15; i++) begin
            tick(); check({tag, "_phase_hold"}, outs, O_PHASE);
        end
        tick(); check({tag, "_done_rise"}, outs, O_DONE);
        tick(); check({tag, "_done_hold"}, outs, O_DONE);
    endtask

    initial begin
        RST          = 1'b1;
        GTX_RST      = 1'b1;
        TX_RESETDONE = 1'b0;
        #1;
        check("reset_t0", outs, O_IDLE);
        tick(3);
        check("reset_held", outs, O_IDLE);
        RST = 1'b0;
        tick(3);
        check("gtx_rst_hold", outs, O_IDLE);

        // Nominal: GTX_RST release, TX_RESETDONE 10 cycles later.
        GTX_RST = 1'b0;
        tick(); check("w4_entry", outs, O_W4);
        tick(9); check("w4_wait", outs, O_W4);
        TX_RESETDONE = 1'b1;
        tick(); check("sync_lat1", outs, O_W4);
        tick(); check("sync_lat2", outs, O_W4);
        seq_from_align("nominal");

        // GTX_RST at Phase_Set cycle 7 aborts; release reruns the full sequence.
        GTX_RST = 1'b1;
        tick(); check("gtx_rst_from_done", outs, O_IDLE);
        GTX_RST = 1'b0;
        tick(); check("w4_again", outs, O_W4);
        tick(); check("align_again", outs, O_ALIGN);
        tick(3);
        tick(); check("phase_again", outs, O_PHASE);
        tick(7);
        check("phase_cycle7", outs, O_PHASE);
        GTX_RST = 1'b1;
        tick(); check("abort_phase", outs, O_IDLE);
        GTX_RST = 1'b0;
        tick(); check("abort_w4", outs, O_W4);
        seq_from_align("rerun");

        // TX_RESETDONE dropped at Align_Wait cycle 2.
        GTX_RST = 1'b1;
        tick(); check("restart_idle", outs, O_IDLE);
        GTX_RST = 1'b0;
        tick(); check("restart_w4", outs, O_W4);
        tick(); check("rd_drop_align0", outs, O_ALIGN);
        tick(2); check("rd_drop_align2", outs, O_ALIGN);
        TX_RESETDONE = 1'b0;
        tick(); check("rd_drop_sync1", outs, O_ALIGN);
        tick(); check("rd_drop_sync2", outs, O_PHASE);
        tick(); check("rd_drop_abort", outs, O_W4);
        tick(3); check("rd_drop_wait", outs, O_W4);
        TX_RESETDONE = 1'b1;
        tick(); check("rd_back_lat1", outs, O_W4);
        tick(); check("rd_back_lat2", outs, O_W4);
        seq_from_align("rd_back");

        // TX_RESETDONE dropped in Sync_Done.
        TX_RESETDONE = 1'b0;
        tick(); check("done_rd_lat1", outs, O_DONE);
        tick(); check("done_rd_lat2", outs, O_DONE);
`ifdef TX_PHASE_RESYNC_EN
        tick(); check("done_rd_resync", outs, O_W4);
        TX_RESETDONE = 1'b1;
        tick(); check("resync_lat1", outs, O_W4);
        tick(); check("resync_lat2", outs, O_W4);
        seq_from_align("resync");
`else
        tick(); check("done_rd_sticky", outs, O_DONE);
        tick(5); check("done_rd_sticky_late", outs, O_DONE);
        TX_RESETDONE = 1'b1;
        tick(3); check("done_rd_restored", outs, O_DONE);
`endif

        // Asynchronous RST mid-Phase_Set.
        GTX_RST = 1'b1;
        tick(); check("pre_rst_idle", outs, O_IDLE);
        GTX_RST = 1'b0;
        tick(); check("pre_rst_w4", outs, O_W4);
        tick(); check("pre_rst_align", outs, O_ALIGN);
        tick(3);
        tick(); check("pre_rst_phase", outs, O_PHASE);
        tick(5);
        #2 RST = 1'b1;
        #1 check("async_rst", outs, O_IDLE);
        tick(); check("rst_held_edge", outs, O_IDLE);
        RST = 1'b0;
        tick(); check("post_rst_w4", outs, O_W4);
        tick(); check("post_rst_sync", outs, O_W4);
        seq_from_align("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
